// File: rtl/res_fifo_ctrl_pkg.sv
// rtl/res_fifo_ctrl_pkg.sv - shared convolver types and constants for the result FIFO controller
package res_fifo_ctrl_pkg;

    // Default result FIFO capacity in 16-bit entries
    localparam int unsigned RES_FIFO_DEPTH = 1352;

    // Width of every job counter and of the result data path
    localparam int unsigned RES_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } res_state_e;

endpackage

// File: rtl/res_fifo_ctrl.sv
// rtl/res_fifo_ctrl.sv - result FIFO write/read arbitration and job sequencing
module res_fifo_ctrl
    import res_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = RES_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [RES_CNT_W-1:0] total_results,
    input  logic                 conv_valid,
    input  logic [RES_CNT_W-1:0] conv_result,
    output logic                 conv_ready,
    input  logic                 rd_req,
    output logic                 rd_valid,
    output logic [RES_CNT_W-1:0] rd_data,
    output logic                 fifo_wenable,
    output logic                 fifo_renable,
    output logic [RES_CNT_W-1:0] fifo_wdata,
    input  logic [RES_CNT_W-1:0] fifo_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_err
);

    localparam logic [RES_CNT_W-1:0] DEPTH_C = RES_CNT_W'(DEPTH);

    res_state_e           state_q, state_d;
    logic [RES_CNT_W-1:0] total_q, total_d;
    logic [RES_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [RES_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [RES_CNT_W-1:0] occ_q, occ_d;
    logic                 rd_err_q, rd_err_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_hit_q, rd_hit_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 active;
    logic                 rd_grant;
    logic                 wr_ok;
    logic                 wr_fire;
    logic                 start_ok;

    // Same-cycle handshakes: a granted read always blocks the write in that cycle
    always_comb begin
        active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        rd_grant = rd_req && active && (occ_q != '0);
        wr_ok    = (state_q == ST_RUN) && (occ_q < DEPTH_C) && (wr_cnt_q < total_q) && !rd_grant;
        wr_fire  = conv_valid && wr_ok;
        start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // Next-state: job sequencing, counter updates and read response staging
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        occ_d      = occ_q;
        rd_err_d   = rd_err_q;
        rd_valid_d = rd_req;
        rd_hit_d   = rd_grant;

        if (start_ok) begin
            total_d  = total_results;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            occ_d    = '0;
            rd_err_d = 1'b0;
            state_d  = (total_results == '0) ? ST_DONE : ST_RUN;
        end else begin
            // Write and read are mutually exclusive, so at most one of these moves occ
            if (wr_fire) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                occ_d    = occ_q + 1'b1;
            end
            if (rd_grant) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                occ_d    = occ_q - 1'b1;
            end
            case (state_q)
                ST_RUN:   if (wr_cnt_d == total_q) state_d = ST_DRAIN;
                ST_DRAIN: if (rd_cnt_d == total_q) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end

        // A request that found nothing to read is flagged until the next job starts
        if (rd_req && !rd_grant) begin
            rd_err_d = 1'b1;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // FSM and status registers; a reset abandons any job in flight
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            total_q    <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            occ_q      <= '0;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            occ_q      <= occ_d;
            rd_err_q   <= rd_err_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // FIFO read data lands one cycle after the grant; failed requests return zero
    always_comb begin
        conv_ready   = wr_ok;
        fifo_wenable = wr_fire;
        fifo_renable = rd_grant;
        fifo_wdata   = conv_result;
        rd_valid     = rd_valid_q;
        rd_data      = rd_hit_q ? fifo_rdata : '0;
        busy         = busy_q;
        done         = done_q;
        rd_err       = rd_err_q;
    end

endmodule

// File: tb/tb_res_fifo_ctrl.sv
// tb/tb_res_fifo_ctrl.sv - self-checking bench for res_fifo_ctrl with a behavioural result FIFO
module tb_res_fifo_ctrl;
    import res_fifo_ctrl_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [15:0] total_results;
    logic        conv_valid;
    logic [15:0] conv_result;
    logic        conv_ready;
    logic        rd_req;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        fifo_wenable;
    logic        fifo_renable;
    logic [15:0] fifo_wdata;
    logic [15:0] fifo_rdata;
    logic        busy;
    logic        done;
    logic        rd_err;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];
    logic [15:0] fifo_mem[$];

    always #5 clk = ~clk;

    res_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .total_results (total_results),
        .conv_valid    (conv_valid),
        .conv_result   (conv_result),
        .conv_ready    (conv_ready),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_wenable  (fifo_wenable),
        .fifo_renable  (fifo_renable),
        .fifo_wdata    (fifo_wdata),
        .fifo_rdata    (fifo_rdata),
        .busy          (busy),
        .done          (done),
        .rd_err        (rd_err)
    );

    // Cycle counter used to check read latency
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sibling FIFO with registered read data
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fifo_mem.delete();
            fifo_rdata <= 16'h0;
        end else begin
            if (fifo_wenable) fifo_mem.push_back(fifo_wdata);
            if (fifo_renable && fifo_mem.size() > 0) fifo_rdata <= fifo_mem.pop_front();
        end
    end

    // Scoreboard: every rd_valid pops one expected response and its due cycle
    always @(negedge clk) begin
        if (n_rst && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_unexpected: got rd_valid data=%0d, required no response", rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rd_data !== e.data || cyc != e.due)
                    $display("FAIL rd_resp: got data=%0d cycle=%0d, required data=%0d cycle=%0d",
                             rd_data, cyc, e.data, e.due);
                else
                    passes++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        n_rst = 1'b1; start = 1'b0; total_results = 16'd0;
        conv_valid = 1'b0; conv_result = 16'd0; rd_req = 1'b0;
        #2 n_rst = 1'b0;
        #10;
        checks++;
        if (dut.state_q !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", dut.state_q, ST_IDLE);
        else passes++;
        checks++;
        if ({busy, done, rd_err, rd_valid, conv_ready, fifo_wenable, fifo_renable} !== 7'b0)
            $display("FAIL reset_flags: got %b required 0000000",
                     {busy, done, rd_err, rd_valid, conv_ready, fifo_wenable, fifo_renable});
        else passes++;
        checks++;
        if (rd_data !== 16'h0 || dut.occ_q !== 16'h0) $display("FAIL reset_data_occ: got %0h/%0d required 0/0", rd_data, dut.occ_q);
        else passes++;
        @(negedge clk) n_rst = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        rd_req = 1'b1;
        push_exp(16'h0);
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_err !== 1'b1) $display("FAIL idle_rd_err: got %b required 1", rd_err);
        else passes++;
        start = 1'b1; total_results = 16'd4;
        tick();
        start = 1'b0; total_results = 16'd0;
        checks++;
        if (dut.state_q !== ST_RUN || busy !== 1'b1 || rd_err !== 1'b0)
            $display("FAIL start_run: got state=%0d busy=%b rd_err=%b required 1/1/0", dut.state_q, busy, rd_err);
        else passes++;
        for (int i = 1; i <= 4; i++) begin
            start = 1'b0;
            conv_valid = 1'b1;
            conv_result = 16'(i);
            if (i == 2) begin
                start = 1'b1;
                total_results = 16'd9;
            end
            #1;
            checks++;
            if (fifo_wenable !== 1'b1 || fifo_wdata !== 16'(i))
                $display("FAIL fill_write: got wen=%b wdata=%0d required 1/%0d", fifo_wenable, fifo_wdata, i);
            else passes++;
            tick();
        end
        start = 1'b0; conv_valid = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== ST_DRAIN || dut.occ_q !== 16'd4 || busy !== 1'b1 || conv_ready !== 1'b0)
            $display("FAIL fill_drain: got state=%0d occ=%0d busy=%b ready=%b required 2/4/1/0",
                     dut.state_q, dut.occ_q, busy, conv_ready);
        else passes++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            rd_req = 1'b1;
            push_exp(16'(i));
            #1;
            checks++;
            if (fifo_renable !== 1'b1) $display("FAIL drain_ren: got %b required 1", fifo_renable);
            else passes++;
            tick();
            rd_req = 1'b0;
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dut.occ_q !== 16'd0)
            $display("FAIL drain_done: got done=%b busy=%b occ=%0d required 1/0/0", done, busy, dut.occ_q);
        else passes++;
    endtask

    task automatic test_backpressure();
        int nwr;
        logic [15:0] next_val;
        logic w;
        start = 1'b1; total_results = 16'd6;
        tick();
        start = 1'b0;
        next_val = 16'd11;
        conv_valid = 1'b1; conv_result = next_val;
        nwr = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            w = fifo_wenable;
            tick();
            if (w) begin nwr++; next_val++; conv_result = next_val; end
        end
        #1;
        checks++;
        if (nwr != 4 || conv_ready !== 1'b0 || dut.occ_q !== 16'd4)
            $display("FAIL full_stall: got writes=%0d ready=%b occ=%0d required 4/0/4", nwr, conv_ready, dut.occ_q);
        else passes++;
        rd_req = 1'b1;
        push_exp(16'd11);
        #1;
        checks++;
        if (fifo_renable !== 1'b1 || conv_ready !== 1'b0)
            $display("FAIL full_read: got ren=%b ready=%b required 1/0", fifo_renable, conv_ready);
        else passes++;
        tick();
        rd_req = 1'b0;
        nwr = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            w = fifo_wenable;
            tick();
            if (w) begin nwr++; next_val++; conv_result = next_val; end
        end
        #1;
        checks++;
        if (nwr != 1 || conv_ready !== 1'b0 || dut.occ_q !== 16'd4)
            $display("FAIL one_more_write: got writes=%0d ready=%b occ=%0d required 1/0/4", nwr, conv_ready, dut.occ_q);
        else passes++;
        rd_req = 1'b1;
        push_exp(16'd12);
        tick();
        rd_req = 1'b0;
        nwr = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            w = fifo_wenable;
            tick();
            if (w) begin nwr++; next_val++; conv_result = next_val; end
        end
        conv_valid = 1'b0;
        #1;
        checks++;
        if (nwr != 1 || dut.state_q !== ST_DRAIN || dut.wr_cnt_q !== 16'd6)
            $display("FAIL last_write: got writes=%0d state=%0d wr_cnt=%0d required 1/2/6", nwr, dut.state_q, dut.wr_cnt_q);
        else passes++;
        for (int v = 13; v <= 16; v++) begin
            rd_req = 1'b1;
            push_exp(16'(v));
            tick();
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || dut.rd_cnt_q !== 16'd6)
            $display("FAIL bp_done: got done=%b rd_cnt=%0d required 1/6", done, dut.rd_cnt_q);
        else passes++;
    endtask

    task automatic test_rd_wr_collision();
        start = 1'b1; total_results = 16'd4;
        tick();
        start = 1'b0;
        conv_valid = 1'b1; conv_result = 16'd21;
        tick();
        conv_result = 16'd22;
        tick();
        conv_result = 16'd23;
        rd_req = 1'b1;
        push_exp(16'd21);
        #1;
        checks++;
        if (dut.occ_q !== 16'd2 || fifo_renable !== 1'b1 || fifo_wenable !== 1'b0 || conv_ready !== 1'b0)
            $display("FAIL collide: got occ=%0d ren=%b wen=%b ready=%b required 2/1/0/0",
                     dut.occ_q, fifo_renable, fifo_wenable, conv_ready);
        else passes++;
        tick();
        rd_req = 1'b0;
        #1;
        checks++;
        if (fifo_wenable !== 1'b1 || fifo_wdata !== 16'd23)
            $display("FAIL collide_next_write: got wen=%b wdata=%0d required 1/23", fifo_wenable, fifo_wdata);
        else passes++;
        tick();
        conv_result = 16'd24;
        tick();
        conv_valid = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== ST_DRAIN || dut.occ_q !== 16'd3)
            $display("FAIL collide_drain: got state=%0d occ=%0d required 2/3", dut.state_q, dut.occ_q);
        else passes++;
        for (int v = 22; v <= 24; v++) begin
            rd_req = 1'b1;
            push_exp(16'(v));
            tick();
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) $display("FAIL collide_done: got %b required 1", done);
        else passes++;
    endtask

    task automatic test_underflow();
        start = 1'b1; total_results = 16'd2;
        tick();
        start = 1'b0;
        rd_req = 1'b1;
        push_exp(16'h0);
        #1;
        checks++;
        if (fifo_renable !== 1'b0) $display("FAIL empty_ren: got %b required 0", fifo_renable);
        else passes++;
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_err !== 1'b1 || dut.state_q !== ST_RUN)
            $display("FAIL empty_err: got rd_err=%b state=%0d required 1/1", rd_err, dut.state_q);
        else passes++;
        conv_valid = 1'b1; conv_result = 16'd31;
        tick();
        conv_result = 16'd32;
        tick();
        conv_valid = 1'b0;
        for (int v = 31; v <= 32; v++) begin
            rd_req = 1'b1;
            push_exp(16'(v));
            tick();
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || rd_err !== 1'b1)
            $display("FAIL err_sticky: got done=%b rd_err=%b required 1/1", done, rd_err);
        else passes++;
        start = 1'b1; total_results = 16'd0;
        tick();
        start = 1'b0;
        checks++;
        if (rd_err !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL err_clear: got rd_err=%b done=%b busy=%b required 0/1/0", rd_err, done, busy);
        else passes++;
    endtask

    task automatic test_reset_midjob();
        start = 1'b1; total_results = 16'd5;
        tick();
        start = 1'b0;
        conv_valid = 1'b1;
        for (int v = 41; v <= 43; v++) begin
            conv_result = 16'(v);
            tick();
        end
        conv_valid = 1'b0;
        #1;
        checks++;
        if (dut.occ_q !== 16'd3 || dut.state_q !== ST_RUN)
            $display("FAIL midjob_occ: got occ=%0d state=%0d required 3/1", dut.occ_q, dut.state_q);
        else passes++;
        n_rst = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== ST_IDLE || dut.occ_q !== 16'd0 || dut.wr_cnt_q !== 16'd0)
            $display("FAIL midjob_reset_state: got state=%0d occ=%0d wr_cnt=%0d required 0/0/0",
                     dut.state_q, dut.occ_q, dut.wr_cnt_q);
        else passes++;
        checks++;
        if ({busy, done, rd_err, rd_valid, conv_ready, fifo_wenable, fifo_renable} !== 7'b0 || rd_data !== 16'h0)
            $display("FAIL midjob_reset_outs: got %b data=%0h required 0000000/0",
                     {busy, done, rd_err, rd_valid, conv_ready, fifo_wenable, fifo_renable}, rd_data);
        else passes++;
        @(negedge clk) n_rst = 1'b1;
        tick();
        start = 1'b1; total_results = 16'd0;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dut.state_q !== ST_DONE)
            $display("FAIL zero_job: got done=%b busy=%b state=%0d required 1/0/3", done, busy, dut.state_q);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_backpressure();
        test_rd_wr_collision();
        test_underflow();
        test_reset_midjob();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL rd_missing: got %0d pending responses required 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
